// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART TX byte stream
// between NUM_REQ byte producers. A grant is held for a whole message and is
// released on an end-of-line byte, a burst limit or an idle timeout, so lines
// from different sources never interleave.
//
// Optional feature macro: UART_ARB_TAG_EN -- when defined, each grant begins
// with one tag byte 8'h30+g (ASCII digit of the owning requester).
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   s_valid  in   [NUM_REQ]    per-requester byte valid
//   s_data   in   [8*NUM_REQ]  per-requester byte, requester i on [8i+7:8i]
//   s_ready  out  [NUM_REQ]    per-requester accept (combinational)
//   m_valid  out  byte valid toward TX buffer
//   m_data   out  [8] byte toward TX buffer
//   m_ready  in   TX buffer accept
//   m_id     out  [3] requester owning the current m_data
//   busy     out  high while a grant is held
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter logic [7:0]  EOL_CHAR  = 8'h0A,
    parameter int unsigned MAX_BURST = 64,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   s_valid,
    input  logic [8*NUM_REQ-1:0] s_data,
    output logic [NUM_REQ-1:0]   s_ready,
    output logic                 m_valid,
    output logic [7:0]           m_data,
    input  logic                 m_ready,
    output logic [2:0]           m_id,
    output logic                 busy
);

    localparam int unsigned CntW = 16;

    typedef enum logic {IDLE, BURST} stateT;

    stateT            state;
    logic [2:0]       grant;
    logic [2:0]       lastGrant;
    logic [CntW-1:0]  burstCnt;
    logic [CntW-1:0]  tmoCnt;

    logic             outFree;
    logic             openSlot;
    logic             selValid;
    logic [7:0]       selData;
    logic             accept;
    logic             relNow;
    logic [2:0]       pick;
    int               rank;
    int               bestRank;

    // Output register can take a new byte when empty or draining this cycle
    assign outFree = !m_valid || m_ready;

`ifdef UART_ARB_TAG_EN
    logic tagPending;
    logic tagLoad;
    assign tagLoad = (state == BURST) && tagPending && outFree;
`else
    localparam logic tagPending = 1'b0;
    localparam logic tagLoad    = 1'b0;
`endif

    // Payload is only accepted once any tag byte has gone out
    assign openSlot = (state == BURST) && outFree && !tagPending;

    // Granted requester's valid/data
    always_comb begin
        selValid = 1'b0;
        selData  = 8'h00;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant == 3'(i)) begin
                selValid = s_valid[i];
                selData  = s_data[8*i +: 8];
            end
        end
    end

    // Only the granted requester sees ready
    always_comb begin
        s_ready = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant == 3'(i)) s_ready[i] = openSlot;
        end
    end

    // Round-robin pick: rank 0 is the requester just after lastGrant
    always_comb begin
        pick     = 3'd0;
        rank     = 0;
        bestRank = int'(NUM_REQ);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            rank = (i + int'(NUM_REQ) - int'(lastGrant) - 1) % int'(NUM_REQ);
            if (s_valid[i] && (rank < bestRank)) begin
                bestRank = rank;
                pick     = 3'(i);
            end
        end
    end

    assign accept = openSlot && selValid;

    // EOL, burst limit and timeout all collapse into one release
    assign relNow = (accept && (selData == EOL_CHAR))
                 || (accept && (MAX_BURST != 0) && (burstCnt == CntW'(MAX_BURST - 1)))
                 || ((state == BURST) && !accept && (tmoCnt == CntW'(TIMEOUT - 1)));

    // Arbiter FSM, counters and output byte register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= 3'd0;
            lastGrant <= 3'(NUM_REQ - 1);
            burstCnt  <= '0;
            tmoCnt    <= '0;
            m_valid   <= 1'b0;
            m_data    <= 8'h00;
            m_id      <= 3'd0;
            busy      <= 1'b0;
`ifdef UART_ARB_TAG_EN
            tagPending <= 1'b0;
`endif
        end else begin
            if (accept) begin
                m_valid <= 1'b1;
                m_data  <= selData;
                m_id    <= grant;
            end else if (tagLoad) begin
                m_valid <= 1'b1;
                m_data  <= 8'h30 + 8'(grant);
                m_id    <= grant;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|s_valid) begin
                        grant <= pick;
                        state <= BURST;
                        busy  <= 1'b1;
`ifdef UART_ARB_TAG_EN
                        tagPending <= 1'b1;
`endif
                    end
                end
                BURST: begin
`ifdef UART_ARB_TAG_EN
                    if (tagLoad) tagPending <= 1'b0;
`endif
                    if (relNow) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        lastGrant <= grant;
                        burstCnt  <= '0;
                        tmoCnt    <= '0;
`ifdef UART_ARB_TAG_EN
                        tagPending <= 1'b0;
`endif
                    end else if (accept) begin
                        burstCnt <= burstCnt + CntW'(1);
                        tmoCnt   <= '0;
                    end else begin
                        tmoCnt <= tmoCnt + CntW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a message-level model of the arbiter.
module tb_uart_tx_arbiter;

    localparam int         N    = 4;
    localparam int         MAXB = 4;
    localparam int         TMO  = 8;
    localparam logic [7:0] EOL  = 8'h0A;
`ifdef UART_ARB_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   s_valid;
    logic [8*N-1:0] s_data;
    logic [N-1:0]   s_ready;
    logic           m_valid;
    logic [7:0]     m_data;
    logic           m_ready;
    logic [2:0]     m_id;
    logic           busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ  (N),
        .EOL_CHAR (EOL),
        .MAX_BURST(MAXB),
        .TIMEOUT  (TMO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_data (s_data),
        .s_ready(s_ready),
        .m_valid(m_valid),
        .m_data (m_data),
        .m_ready(m_ready),
        .m_id   (m_id),
        .busy   (busy)
    );

    int nVec = 0;
    int nBad = 0;

    // Requester byte queues and stimulus knobs
    logic [7:0] rq [N][$];
    bit         mute [N];
    logic       mr;

    // Message-level model: who owns the stream, how much it sent, how long idle
    int         owner;
    int         lastOwner;
    int         sentCnt;
    int         quietCnt;
    bit         tagOwed;
    bit         outFull;
    logic [7:0] outByte;
    int         outId;

    // Observed output stream and expected literal stream
    logic [10:0] logQ [$];
    int          logCyc [$];
    logic [10:0] expQ [$];
    int          cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rrPick(input logic [N-1:0] v);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (lastOwner + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic modelReset();
        owner = -1; lastOwner = N - 1; sentCnt = 0; quietCnt = 0;
        tagOwed = 1'b0; outFull = 1'b0; outByte = 8'h00; outId = 0;
    endtask

    task automatic send(input int id, input string s);
        for (int k = 0; k < s.len(); k++) rq[id].push_back(8'(s[k]));
    endtask

    task automatic expMsg(input int id, input string s);
        if (TAG) expQ.push_back({3'(id), 8'h30 + 8'(id)});
        for (int k = 0; k < s.len(); k++) expQ.push_back({3'(id), 8'(s[k])});
    endtask

    task automatic cmpLog(input string name);
        check($sformatf("%s count", name), 32'(logQ.size()), 32'(expQ.size()));
        for (int i = 0; i < logQ.size() && i < expQ.size(); i++)
            check($sformatf("%s byte%0d", name, i), 32'(logQ[i]), 32'(expQ[i]));
        logQ.delete(); logCyc.delete(); expQ.delete();
    endtask

    // Async reset with immediate check of the outputs, then one clock in reset
    task automatic doReset();
        rst_n = 1'b0;
        s_valid = '0;
        s_data = '0;
        #1;
        check("rst m_valid", 32'(m_valid), 32'd0);
        check("rst m_data", 32'(m_data), 32'd0);
        check("rst m_id", 32'(m_id), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst s_ready", 32'(s_ready), 32'd0);
        modelReset();
        for (int i = 0; i < N; i++) rq[i].delete();
        logQ.delete(); logCyc.delete(); expQ.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One clock: drive, compare against model, advance model
    task automatic step();
        logic [N-1:0]   sv;
        logic [8*N-1:0] sd;
        logic [N-1:0]   rdyExp;
        bit             slotOpen, takes, tagGo, done;
        logic [7:0]     b;
        for (int i = 0; i < N; i++) begin
            sv[i] = (rq[i].size() > 0) && !mute[i];
            sd[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
        end
        s_valid = sv; s_data = sd; m_ready = mr;
        #1;
        slotOpen = !outFull || mr;
        rdyExp = '0;
        if (owner >= 0 && slotOpen && !tagOwed) rdyExp[owner] = 1'b1;
        check("busy", 32'(busy), 32'(owner >= 0));
        check("m_valid", 32'(m_valid), 32'(outFull));
        if (outFull) begin
            check("m_data", 32'(m_data), 32'(outByte));
            check("m_id", 32'(m_id), 32'(outId));
        end
        check("s_ready", 32'(s_ready), 32'(rdyExp));
        if (m_valid === 1'b1 && mr) begin
            logQ.push_back({m_id, m_data});
            logCyc.push_back(cyc);
        end

        takes = 1'b0; b = 8'h00;
        if (owner >= 0) begin
            takes = rdyExp[owner] && sv[owner];
            if (takes) b = sd[8*owner +: 8];
        end
        tagGo = (owner >= 0) && tagOwed && slotOpen;
        if (takes) begin
            outFull = 1'b1; outByte = b; outId = owner;
            void'(rq[owner].pop_front());
        end else if (tagGo) begin
            outFull = 1'b1; outByte = 8'h30 + 8'(owner); outId = owner;
        end else if (mr) begin
            outFull = 1'b0;
        end
        if (owner < 0) begin
            if (|sv) begin
                owner = rrPick(sv);
                tagOwed = TAG;
            end
        end else begin
            if (takes) begin
                sentCnt++; quietCnt = 0;
                done = (b == EOL) || (MAXB != 0 && sentCnt == MAXB);
            end else begin
                quietCnt++;
                done = (quietCnt == TMO);
            end
            if (tagGo) tagOwed = 1'b0;
            if (done) begin
                lastOwner = owner; owner = -1;
                sentCnt = 0; quietCnt = 0; tagOwed = 1'b0;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic runN(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int guard;
        int len;
        int iA, iB;
        mr = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) mute[i] = 1'b0;
        doReset();

        // Single requester line
        send(1, "AB\n"); expMsg(1, "AB\n");
        runN(10);
        if (logQ.size() > 0)
            check("line consecutive", 32'(logCyc[logQ.size()-1] - logCyc[0]), 32'(logQ.size() - 1));
        cmpLog("single");

        // Contention from reset, then a repeat: req0 first both times
        doReset();
        send(0, "X\n"); send(2, "Y\n");
        expMsg(0, "X\n"); expMsg(2, "Y\n");
        runN(14);
        iB = TAG ? 3 : 2;
        if (logQ.size() > iB) check("grant gap", 32'(logCyc[iB] - logCyc[iB-1]), 32'd2);
        cmpLog("contention");
        send(0, "X\n"); send(2, "Y\n");
        expMsg(0, "X\n"); expMsg(2, "Y\n");
        runN(14);
        cmpLog("rr repeat");

        // Burst limit hands the stream to req0 and back
        send(3, "abcdefghij"); send(0, "Z\n");
        expMsg(3, "abcd"); expMsg(0, "Z\n"); expMsg(3, "efgh"); expMsg(3, "ij");
        runN(55);
        cmpLog("burst limit");

        // Timeout after req1 goes quiet
        send(1, "Q"); send(2, "R\n");
        expMsg(1, "Q"); expMsg(2, "R\n");
        runN(25);
        iA = TAG ? 1 : 0;
        iB = TAG ? 2 : 1;
        if (logQ.size() > iB) check("timeout gap", 32'(logCyc[iB] - logCyc[iA]), 32'd10);
        cmpLog("timeout");

        // Back-pressure for 5 cycles
        send(0, "MN\n"); expMsg(0, "MN\n");
        for (int k = 0; k < 20; k++) begin
            mr = !(k >= 3 && k < 8);
            step();
            if (k == 4) begin
                check("bp hold valid", 32'(m_valid), 32'd1);
                check("bp hold data", 32'(m_data), TAG ? 32'h4D : 32'h4E);
                check("bp hold id", 32'(m_id), 32'd0);
                check("bp s_ready", 32'(s_ready), 32'd0);
            end
        end
        mr = 1'b1;
        cmpLog("backpressure");

        // Reset while req1's third byte is offered
        send(1, "uvw\n");
        for (guard = 0; guard < 20 && !(owner == 1 && sentCnt == 2); guard++) step();
        check("reach 3rd byte", 32'(guard < 20), 32'd1);
        doReset();
        send(1, "ok\n"); expMsg(1, "ok\n");
        runN(12);
        cmpLog("post reset");

        // EOL coinciding with burst limit: one release only
        send(2, "pqr\ns\n");
        expMsg(2, "pqr\n"); expMsg(2, "s\n");
        runN(22);
        iB = TAG ? 5 : 4;
        if (logQ.size() > iB) check("coincident gap", 32'(logCyc[iB] - logCyc[iB-1]), 32'd2);
        cmpLog("coincident");

        // Randomized traffic with stalls and dropped valids
        for (int t = 0; t < 3000; t++) begin
            mr = ($urandom_range(0, 3) != 0);
            if ((t % 200) >= 100 && (t % 200) < 112) mr = 1'b0;
            for (int i = 0; i < N; i++) begin
                mute[i] = ($urandom_range(0, 9) == 0);
                if (rq[i].size() == 0 && $urandom_range(0, 5) == 0) begin
                    len = $urandom_range(1, 6);
                    for (int k = 0; k < len; k++)
                        rq[i].push_back(($urandom_range(0, 3) == 0) ? EOL : 8'(8'h41 + 8'($urandom_range(0, 25))));
                end
            end
            step();
            if (logQ.size() > 64) begin
                logQ.delete(); logCyc.delete();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
